// File: rtl/uart_pkt_rx_if.sv
// Bus bundle for uart_pkt_rx: byte/bit strobes from the UART receiver,
// payload read port, frame status and error pulses.
interface uart_pkt_rx_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       crc_din;
  logic       crc_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       pkt_valid;
  logic [4:0] pkt_len;
  logic       pkt_ack;
  logic [3:0] err;

  // Producer/consumer side: feeds bytes and bits, reads back the frame.
  modport master (
    output rx_data, rx_ready, crc_din, crc_en, rd_addr, pkt_ack,
    input  rd_data, pkt_valid, pkt_len, err
  );

  // Receiver side.
  modport slave (
    input  rx_data, rx_ready, crc_din, crc_en, rd_addr, pkt_ack,
    output rd_data, pkt_valid, pkt_len, err
  );
endinterface

// File: rtl/uart_pkt_rx.sv
// Packet receiver: SOF, LEN, payload, CRC-8 byte framing on top of a UART
// byte stream. A CRC-8 (poly 0x07) runs on the serial bit stream in wire
// order; the frame is held in a 16x8 buffer until the consumer acks it.
module uart_pkt_rx #(
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         MAXLEN  = 16,
  parameter int         TIMEOUT = 240
) (
  input  logic          clk,
  input  logic          reset,
  uart_pkt_rx_if.slave  bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAXLEN);
  localparam logic [7:0] TMO_LOAD  = 8'(TIMEOUT);

  // One-hot error codes, bit 3..0 = {overrun, timeout, len, crc}.
  localparam logic [3:0] ERR_OVR = 4'b1000;
  localparam logic [3:0] ERR_TMO = 4'b0100;
  localparam logic [3:0] ERR_LEN = 4'b0010;
  localparam logic [3:0] ERR_CRC = 4'b0001;

  typedef enum logic [2:0] {IDLE, LEN, DATA, CRC, HOLD} state_t;

  state_t     state;
  logic [7:0] crc;
  logic [7:0] crc_snap;
  logic [7:0] timer;
  logic [4:0] index;
  logic [4:0] length;
  logic       pkt_valid;
  logic [4:0] pkt_len;
  logic [3:0] err;

  logic [7:0] mem [16];
  logic [7:0] rd_data;

  logic       sof_hit;
  logic [4:0] index_inc;
  logic       len_ok;

  // One serial step of the CRC-8 shift register, MSB feedback.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
    logic fb;
    fb = c[7] ^ d;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign sof_hit   = (state == IDLE) && bus.rx_ready && (bus.rx_data == SOF);
  assign index_inc = index + 5'd1;
  assign len_ok    = (bus.rx_data >= 8'd1) && (bus.rx_data <= MAX_LEN_B);

  // CRC engine: free-running on crc_en in every state, restarted by an
  // accepted SOF. A bit arriving in the same cycle as the restart is
  // folded into the fresh register rather than lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= 8'h00;
    end else if (sof_hit) begin
      crc <= bus.crc_en ? crc_step(8'h00, bus.crc_din) : 8'h00;
    end else if (bus.crc_en) begin
      crc <= crc_step(crc, bus.crc_din);
    end
  end

  // Frame FSM with gap timer, write index, CRC snapshot and registered
  // status/error outputs. Each state can raise at most one error kind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= 8'd0;
      index     <= 5'd0;
      length    <= 5'd0;
      crc_snap  <= 8'h00;
      pkt_valid <= 1'b0;
      pkt_len   <= 5'd0;
      err       <= 4'b0000;
    end else begin
      err <= 4'b0000;
      case (state)
        IDLE: begin
          if (sof_hit) begin
            state <= LEN;
            timer <= TMO_LOAD;
            index <= 5'd0;
          end
        end

        LEN: begin
          if (bus.rx_ready) begin
            if (len_ok) begin
              state  <= DATA;
              length <= bus.rx_data[4:0];
              index  <= 5'd0;
              timer  <= TMO_LOAD;
            end else begin
              state <= IDLE;
              err   <= ERR_LEN;
            end
          end else if (timer == 8'd0) begin
            state <= IDLE;
            err   <= ERR_TMO;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        DATA: begin
          if (bus.rx_ready) begin
            index <= index_inc;
            timer <= TMO_LOAD;
            // The register already holds the last payload bit, which was
            // shifted in the cycle before this byte strobe.
            if (index_inc == length) begin
              state    <= CRC;
              crc_snap <= crc;
            end
          end else if (timer == 8'd0) begin
            state <= IDLE;
            err   <= ERR_TMO;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        CRC: begin
          if (bus.rx_ready) begin
            timer <= TMO_LOAD;
            if (bus.rx_data == crc_snap) begin
              state     <= HOLD;
              pkt_valid <= 1'b1;
              pkt_len   <= length;
            end else begin
              state <= IDLE;
              err   <= ERR_CRC;
            end
          end else if (timer == 8'd0) begin
            state <= IDLE;
            err   <= ERR_TMO;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        HOLD: begin
          // Any byte while a frame is held is dropped, even one that
          // arrives together with the ack.
          if (bus.rx_ready) begin
            err <= ERR_OVR;
          end
          if (bus.pkt_ack) begin
            state     <= IDLE;
            pkt_valid <= 1'b0;
            pkt_len   <= 5'd0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Payload buffer: written only while collecting payload, read port
  // registered every cycle. Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if ((state == DATA) && bus.rx_ready) begin
      mem[index[3:0]] <= bus.rx_data;
    end
    rd_data <= mem[bus.rd_addr];
  end

  assign bus.rd_data   = rd_data;
  assign bus.pkt_valid = pkt_valid;
  assign bus.pkt_len   = pkt_len;
  assign bus.err       = err;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Self-checking bench for uart_pkt_rx: directed framing scenarios plus
// randomized frames, checked against a frame-level reference model.
module tb_uart_pkt_rx;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         MAXLEN  = 16;
  localparam int         TIMEOUT = 240;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_pkt_rx_if bus();

  uart_pkt_rx #(.SOF(SOF), .MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Error pulse monitor: counts pulse cycles per bit and multi-bit cycles.
  int err_total = 0;
  int err_multi = 0;
  int err_cnt [4] = '{0, 0, 0, 0};
  int base_total, base_multi;
  int base_cnt [4];

  always @(negedge clk) begin
    if (!reset && bus.err != 4'b0000) begin
      err_total = err_total + 1;
      for (int b = 0; b < 4; b++) if (bus.err[b]) err_cnt[b] = err_cnt[b] + 1;
      if ($countones(bus.err) > 1) err_multi = err_multi + 1;
      $display("  err pulse %b at %0t", bus.err, $time);
    end
  end

  logic [7:0] pl [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    base_total = err_total;
    base_multi = err_multi;
    for (int b = 0; b < 4; b++) base_cnt[b] = err_cnt[b];
  endtask

  // Expect exactly one error pulse of kind bit_idx since snap(), or none if -1.
  task automatic expect_err(input string tag, input int bit_idx);
    check({tag, "_errcount"}, 32'(err_total - base_total), (bit_idx < 0) ? 32'd0 : 32'd1);
    if (bit_idx >= 0) check({tag, "_errkind"}, 32'(err_cnt[bit_idx] - base_cnt[bit_idx]), 32'd1);
    check({tag, "_errmulti"}, 32'(err_multi - base_multi), 32'd0);
  endtask

  // Serial bits LSB first, then the byte strobe one cycle after the last bit.
  task automatic send_byte(input logic [7:0] b, input bit ack_last_bit, input bit ack_with_ready);
    for (int i = 0; i < 8; i++) begin
      bus.crc_en  = 1'b1;
      bus.crc_din = b[i];
      bus.pkt_ack = ack_last_bit && (i == 7);
      tick();
    end
    bus.crc_en   = 1'b0;
    bus.crc_din  = 1'b0;
    bus.pkt_ack  = ack_with_ready;
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_ready = 1'b0;
    bus.pkt_ack  = 1'b0;
  endtask

  task automatic sb(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b0);
  endtask

  // Reference CRC: CRC-8/0x07 over the message {LEN, payload} as a bit
  // stream in wire order (each byte LSB first), starting from zero.
  function automatic logic [7:0] model_crc(input int n);
    logic [7:0] msg [$];
    logic [7:0] c;
    c = 8'h00;
    msg.push_back(8'(n));
    for (int i = 0; i < n; i++) msg.push_back(pl[i]);
    foreach (msg[k]) begin
      for (int i = 0; i < 8; i++) begin
        if (c[7] ^ msg[k][i]) c = {c[6:0], 1'b0} ^ 8'h07;
        else                  c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  task automatic check_buffer(input string tag, input int n);
    for (int a = 0; a < n; a++) begin
      bus.rd_addr = 4'(a);
      tick();
      check($sformatf("%s_rd%0d", tag, a), 32'(bus.rd_data), 32'(pl[a]));
    end
  endtask

  // Full frame; a nonzero mask corrupts the CRC byte. ack_into_sof acks a
  // previously held frame on the SOF's last bit so SOF lands right after.
  task automatic run_frame(input string tag, input int n, input logic [7:0] mask, input bit ack_into_sof);
    logic [7:0] c;
    c = model_crc(n) ^ mask;
    snap();
    send_byte(SOF, ack_into_sof, 1'b0);
    sb(8'(n));
    for (int i = 0; i < n; i++) sb(pl[i]);
    sb(c);
    $display("frame %s len=%0d crc=%h mask=%h", tag, n, c, mask);
    if (mask == 8'h00) begin
      check({tag, "_valid"}, 32'(bus.pkt_valid), 32'd1);
      check({tag, "_len"}, 32'(bus.pkt_len), 32'(n));
      check_buffer(tag, n);
      tick();
      expect_err(tag, -1);
    end else begin
      check({tag, "_valid"}, 32'(bus.pkt_valid), 32'd0);
      tick();
      expect_err(tag, 0);
    end
  endtask

  task automatic ack(input string tag);
    bus.pkt_ack = 1'b1;
    tick();
    bus.pkt_ack = 1'b0;
    check({tag, "_ackvalid"}, 32'(bus.pkt_valid), 32'd0);
  endtask

  task automatic rand_payload(input int n);
    for (int i = 0; i < n; i++) pl[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] mask;
    logic [7:0] c;

    bus.rx_data = 8'h00; bus.rx_ready = 1'b0; bus.crc_din = 1'b0;
    bus.crc_en = 1'b0; bus.rd_addr = 4'd0; bus.pkt_ack = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(bus.pkt_valid), 32'd0);
    check("rst_len", 32'(bus.pkt_len), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    tick();

    // Good frame A5 02 11 22 crc, then ack
    pl[0] = 8'h11; pl[1] = 8'h22;
    run_frame("good", 2, 8'h00, 1'b0);
    ack("good");

    // Corrupted CRC, then a good frame proves the FSM is back in IDLE
    run_frame("badcrc", 2, 8'h01, 1'b0);
    rand_payload(3);
    run_frame("after_bad", 3, 8'h00, 1'b0);
    ack("after_bad");

    // Length out of range, both ends
    snap(); sb(SOF); sb(8'h00); tick();
    expect_err("len0", 1);
    check("len0_valid", 32'(bus.pkt_valid), 32'd0);
    snap(); sb(SOF); sb(8'h11); tick();
    expect_err("len17", 1);
    check("len17_valid", 32'(bus.pkt_valid), 32'd0);

    // Maximum length frame
    rand_payload(16);
    run_frame("max", 16, 8'h00, 1'b0);
    ack("max");

    // Gap timeout: no byte after A5 03 01
    snap(); sb(SOF); sb(8'h03); sb(8'h01);
    repeat (TIMEOUT) tick();
    check("tmo_pre", 32'(bus.err), 32'd0);
    tick();
    check("tmo_edge", 32'(bus.err), 32'(4'b0100));
    tick();
    check("tmo_after", 32'(bus.err), 32'd0);
    expect_err("tmo", 2);
    check("tmo_valid", 32'(bus.pkt_valid), 32'd0);

    // Byte strobe lands exactly on the expiry cycle: frame continues
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    snap(); sb(SOF); sb(8'h03); sb(pl[0]);
    repeat (TIMEOUT + 1 - 9) tick();
    sb(pl[1]); sb(pl[2]); sb(model_crc(3));
    $display("frame expiry_edge len=3 crc=%h", model_crc(3));
    check("edge_valid", 32'(bus.pkt_valid), 32'd1);
    check("edge_len", 32'(bus.pkt_len), 32'd3);
    tick();
    expect_err("edge", -1);

    // Overrun while held: byte dropped, buffer unchanged
    snap(); sb(SOF); tick();
    expect_err("ovr", 3);
    check("ovr_valid", 32'(bus.pkt_valid), 32'd1);
    check_buffer("ovr", 3);

    // Ack coincident with a byte: ack taken, byte dropped, no SOF detect
    snap();
    send_byte(SOF, 1'b0, 1'b1);
    check("ovrack_err", 32'(bus.err), 32'(4'b1000));
    check("ovrack_valid", 32'(bus.pkt_valid), 32'd0);
    tick();
    expect_err("ovrack", 3);
    rand_payload(5);
    run_frame("after_ovrack", 5, 8'h00, 1'b0);

    // Back-to-back: SOF strobe in the cycle right after HOLD -> IDLE
    rand_payload(4);
    run_frame("b2b", 4, 8'h00, 1'b1);
    ack("b2b");

    // Reset in DATA after 1 of 4 payload bytes
    for (int i = 0; i < 4; i++) begin
      pl[i] = 8'($urandom_range(0, 255));
      if (pl[i] == SOF) pl[i] = 8'h5A;
    end
    snap(); sb(SOF); sb(8'h04); sb(pl[0]);
    #2 reset = 1'b1;
    #1;
    check("mrst_valid", 32'(bus.pkt_valid), 32'd0);
    check("mrst_len", 32'(bus.pkt_len), 32'd0);
    check("mrst_err", 32'(bus.err), 32'd0);
    tick(); tick();
    reset = 1'b0;
    sb(pl[1]); sb(pl[2]); sb(pl[3]);
    c = model_crc(4);
    if (c != SOF) sb(c);
    tick();
    check("mrst_tail_valid", 32'(bus.pkt_valid), 32'd0);
    expect_err("mrst", -1);
    rand_payload(4);
    run_frame("after_rst", 4, 8'h00, 1'b0);
    ack("after_rst");

    // Randomized frames, some with corrupted CRC
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, MAXLEN);
      rand_payload(n);
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame($sformatf("rand%0d", k), n, mask, 1'b0);
      if (mask == 8'h00) ack($sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
